// File: rtl/instr_encoder_if.sv
// Request/response bundle between a field source and instr_encoder.
//   slave  : encoder view (takes request fields and out_ready, drives in_ready and the output word)
//   master : producer/consumer view (drives request fields and out_ready)
// Parameters ADDR_W / CNT_W must match the encoder instance.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [CNT_W-1:0]  out_count;

  modport slave (
    input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, out_count
  );

  modport master (
    output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, out_count
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: assembles RV32I L/S/I/B instruction words from decoded fields,
// scattering immediate bits into the ISA slots, tags each word with a
// word-aligned address and counts words taken by the consumer.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      pulse: restart address at BASE_ADDR, clear out_count
//   bus        instr_encoder_if.slave (request fields in, encoded word out)
// Optional feature: define IMM_RANGE_CHECK_EN to flag immediates that do not
// fit the selected format on out_err; otherwise out_err is tied low.
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  instr_encoder_if.slave   bus
);

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] FMT_L = 2'd0;
  localparam logic [1:0] FMT_S = 2'd1;
  localparam logic [1:0] FMT_I = 2'd2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic              valid_q,     valid_d;
  logic [XLEN-1:0]   instr_q,     instr_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [CNT_W-1:0]  count_q,     count_d;

  logic              accept;
  logic              handshake;
  logic [ADDR_W-1:0] slot_addr;
  logic [XLEN-1:0]   enc_instr;
  logic [XLEN-1:0]   imm;

  assign imm       = bus.in_imm;
  assign accept    = bus.in_valid && bus.in_ready;
  assign handshake = valid_q && bus.out_ready;
  // A start coinciding with an accept hands that word the base address.
  assign slot_addr = start ? BASE_ADDR : next_addr_q;

  // Output register reloads whenever it is empty or being drained.
  assign bus.in_ready = !valid_q || bus.out_ready;

  // Field scatter into the instruction word.
  always_comb begin
    enc_instr = '0;
    case (bus.in_fmt)
      FMT_L:   enc_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
      FMT_S:   enc_instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], OP_STORE};
      FMT_I:   enc_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_IMM};
      default: enc_instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                            imm[4:1], imm[11], OP_BRANCH};
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic err_q, err_d;
  logic imm_err;

  // Upper bits must be a pure sign extension; branch offsets must be even.
  always_comb begin
    imm_err = 1'b0;
    if (bus.in_fmt == 2'd3) begin
      imm_err = !((&imm[31:12]) || (~|imm[31:12])) || imm[0];
    end else begin
      imm_err = !((&imm[31:11]) || (~|imm[31:11]));
    end
  end

  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = imm_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.out_err = err_q;
`else
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:13];
  assign bus.out_err   = 1'b0;
`endif

  // Next-state for the output word, address generator and consumer count.
  always_comb begin
    valid_d     = valid_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    next_addr_d = next_addr_q;
    count_d     = count_q;

    if (start) begin
      next_addr_d = BASE_ADDR;
    end

    if (accept) begin
      valid_d     = 1'b1;
      instr_d     = enc_instr;
      addr_d      = slot_addr;
      next_addr_d = slot_addr + ADDR_STEP;
    end else if (handshake) begin
      valid_d = 1'b0;
    end

    // start wins over a same-cycle handshake: that word is not counted.
    if (start) begin
      count_d = '0;
    end else if (handshake) begin
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      instr_q     <= '0;
      addr_q      <= BASE_ADDR;
      next_addr_q <= BASE_ADDR;
      count_q     <= '0;
    end else begin
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      count_q     <= count_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_instr = instr_q;
  assign bus.out_addr  = addr_q;
  assign bus.out_count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: scoreboard of expected words pushed at accept,
// popped and compared at each output handshake, plus directed scenario checks.
module tb_instr_encoder;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 16;
  // Base near the top of the address space so the wrap to 0 is exercised.
  localparam logic [31:0] BASE   = 32'hFFFF_FFF0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  instr_encoder #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(BASE),
    .CNT_W    (CNT_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bus  (bus)
  );

  exp_t        sb[$];
  exp_t        mon_e;
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] model_addr  = BASE;
  logic [15:0] exp_cnt     = '0;

  // Reference encoder: places each field bit range explicitly.
  function automatic logic [31:0] model_encode(input logic [1:0] fmt, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [2:0] f3, input logic [31:0] imm);
    logic [31:0] w;
    w = '0;
    w[14:12] = f3;
    w[19:15] = rs1;
    case (fmt)
      2'd0, 2'd2: begin
        w[6:0]   = (fmt == 2'd0) ? 7'h03 : 7'h13;
        w[11:7]  = rd;
        w[31:20] = imm[11:0];
      end
      2'd1: begin
        w[6:0]   = 7'h23;
        w[11:7]  = imm[4:0];
        w[24:20] = rs2;
        w[31:25] = imm[11:5];
      end
      default: begin
        w[6:0]   = 7'h63;
        w[7]     = imm[11];
        w[11:8]  = imm[4:1];
        w[24:20] = rs2;
        w[30:25] = imm[10:5];
        w[31]    = imm[12];
      end
    endcase
    return w;
  endfunction

  function automatic logic model_err(input logic [1:0] fmt, input logic [31:0] imm);
`ifdef IMM_RANGE_CHECK_EN
    int s;
    s = int'(imm);
    if (fmt == 2'd3) return (s < -4096) || (s > 4095) || imm[0];
    return (s < -2048) || (s > 2047);
`else
    return (fmt == 2'd3) && 1'b0 && imm[0];
`endif
  endfunction

  // Immediate generator: extracts the sign-extended immediate from a word.
  function automatic logic [31:0] imm_gen(input logic [31:0] w);
    case (w[6:0])
      7'h03, 7'h13: return {{20{w[31]}}, w[31:20]};
      7'h23:        return {{20{w[31]}}, w[31:25], w[11:7]};
      7'h63:        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default:      return 32'h0;
    endcase
  endfunction

  // Scoreboard consumer and count tracker.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = '0;
    end else begin
      vectors++;
      if (bus.out_count !== exp_cnt) begin
        miscompares++;
        $display("FAIL out_count got %0d expected %0d", bus.out_count, exp_cnt);
      end
      if (bus.out_valid && bus.out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_word got instr=%h addr=%h expected no word",
                   bus.out_instr, bus.out_addr);
        end else begin
          mon_e = sb.pop_front();
          if ({bus.out_instr, bus.out_addr, bus.out_err} !== mon_e) begin
            miscompares++;
            $display("FAIL sb_word got instr=%h addr=%h err=%b expected instr=%h addr=%h err=%b",
                     bus.out_instr, bus.out_addr, bus.out_err, mon_e.instr, mon_e.addr, mon_e.err);
          end
        end
      end
      if (start) exp_cnt = '0;
      else if (bus.out_valid && bus.out_ready) exp_cnt = exp_cnt + 16'd1;
    end
  end

  // Presents a request and waits (bounded) until it is accepted; leaves in_valid high.
  task automatic send(input logic [1:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
    exp_t e;
    bit   done;
    done          = 1'b0;
    bus.in_fmt    = fmt;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_imm    = imm;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.addr     = start ? BASE : model_addr;
        model_addr = e.addr + 32'd4;
        e.instr    = model_encode(fmt, rd, rs1, rs2, f3, imm);
        e.err      = model_err(fmt, imm);
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL send_timeout got no accept in 50 cycles expected accept");
    end
  endtask

  task automatic idle_cycle();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_fmt = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_funct3 = '0; bus.in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({bus.out_valid, bus.out_instr, bus.out_addr, bus.out_err, bus.out_count} !==
        {1'b0, 32'h0, BASE, 1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_values got v=%b i=%h a=%h e=%b c=%0d expected v=0 i=0 a=%h e=0 c=0",
               bus.out_valid, bus.out_instr, bus.out_addr, bus.out_err, bus.out_count, BASE);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready got %b expected 1", bus.in_ready);
    end
    rst = 1'b0;
    model_addr = BASE;
  endtask

  task automatic test_i_basic();
    bus.out_ready = 1'b1;
    send(2'd2, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.out_valid, bus.out_instr, bus.out_addr} !== {1'b1, 32'h00500093, BASE}) begin
      miscompares++;
      $display("FAIL i_basic got v=%b instr=%h addr=%h expected v=1 instr=00500093 addr=%h",
               bus.out_valid, bus.out_instr, bus.out_addr, BASE);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL i_drain got out_valid=%b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_load_store();
    send(2'd0, 5'd2, 5'd1, 5'd0, 3'd2, 32'd8);
    vectors++;
    if ({bus.out_instr, bus.out_addr} !== {32'h0080A103, BASE + 32'd4}) begin
      miscompares++;
      $display("FAIL load got instr=%h addr=%h expected instr=0080a103 addr=%h",
               bus.out_instr, bus.out_addr, BASE + 32'd4);
    end
    send(2'd1, 5'd0, 5'd1, 5'd2, 3'd2, 32'd12);
    vectors++;
    if ({bus.out_instr, bus.out_addr} !== {32'h0020A623, BASE + 32'd8}) begin
      miscompares++;
      $display("FAIL store got instr=%h addr=%h expected instr=0020a623 addr=%h",
               bus.out_instr, bus.out_addr, BASE + 32'd8);
    end
    idle_cycle();
  endtask

  task automatic test_branch();
    logic [31:0] rt;
    send(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC);
    vectors++;
    if (bus.out_instr !== 32'hFE208EE3) begin
      miscompares++;
      $display("FAIL branch got instr=%h expected fe208ee3", bus.out_instr);
    end
    rt = imm_gen(bus.out_instr);
    vectors++;
    if (rt !== 32'hFFFF_FFFC) begin
      miscompares++;
      $display("FAIL branch_roundtrip got imm=%h expected fffffffc", rt);
    end
    idle_cycle();
  endtask

  task automatic test_roundtrip();
    logic [1:0]  fmt;
    logic [31:0] imm;
    logic [31:0] rt;
    int          v;
    for (int n = 0; n < 12; n++) begin
      fmt = 2'(n % 4);
      v   = int'($urandom_range(4095)) - 2048;
      if (fmt == 2'd3) v = v * 2;
      imm = 32'(v);
      send(fmt, 5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
           3'($urandom_range(7)), imm);
      rt = imm_gen(bus.out_instr);
      vectors++;
      if (rt !== imm) begin
        miscompares++;
        $display("FAIL roundtrip fmt=%0d got imm=%h expected %h", fmt, rt, imm);
      end
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    bus.out_ready = 1'b0;
    send(2'd2, 5'd3, 5'd4, 5'd0, 3'd0, 32'd7);
    held = model_encode(2'd2, 5'd3, 5'd4, 5'd0, 3'd0, 32'd7);
    fork
      send(2'd0, 5'd5, 5'd6, 5'd0, 3'd3, 32'hFFFF_FFF0);
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          vectors++;
          if ({bus.in_ready, bus.out_valid, bus.out_instr} !== {1'b0, 1'b1, held}) begin
            miscompares++;
            $display("FAIL stall_hold cycle=%0d got rdy=%b v=%b instr=%h expected rdy=0 v=1 instr=%h",
                     k, bus.in_ready, bus.out_valid, bus.out_instr, held);
          end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    send(2'd1, 5'd0, 5'd7, 5'd8, 3'd1, 32'd100);
    send(2'd3, 5'd0, 5'd9, 5'd10, 3'd5, 32'd64);
    idle_cycle();
    idle_cycle();
  endtask

  task automatic test_range();
    logic [11:0] top;
    logic        exp_err;
    bus.out_ready = 1'b1;
    send(2'd2, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    top     = bus.out_instr[31:20];
    exp_err = model_err(2'd2, 32'd2048);
    vectors++;
    if ({top, bus.out_err} !== {12'h800, exp_err}) begin
      miscompares++;
      $display("FAIL range_i got imm_field=%h err=%b expected imm_field=800 err=%b",
               top, bus.out_err, exp_err);
    end
    send(2'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
    exp_err = model_err(2'd3, 32'd3);
    vectors++;
    if (bus.out_err !== exp_err) begin
      miscompares++;
      $display("FAIL range_b got err=%b expected %b", bus.out_err, exp_err);
    end
    idle_cycle();
  endtask

  task automatic test_start();
    logic [31:0] held;
    bus.out_ready = 1'b1;
    start = 1'b1;
    send(2'd2, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    start = 1'b0;
    vectors++;
    if ({bus.out_addr, bus.out_count} !== {BASE, 16'h0}) begin
      miscompares++;
      $display("FAIL start_accept got addr=%h count=%0d expected addr=%h count=0",
               bus.out_addr, bus.out_count, BASE);
    end
    send(2'd2, 5'd2, 5'd0, 5'd0, 3'd0, 32'd2);
    bus.in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_addr = BASE;
    vectors++;
    if ({bus.out_valid, bus.out_count} !== {1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL start_handshake got v=%b count=%0d expected v=0 count=0",
               bus.out_valid, bus.out_count);
    end
    bus.out_ready = 1'b0;
    send(2'd0, 5'd3, 5'd3, 5'd0, 3'd1, 32'd4);
    bus.in_valid = 1'b0;
    held = bus.out_instr;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    model_addr = BASE;
    vectors++;
    if ({bus.out_valid, bus.out_instr} !== {1'b1, model_encode(2'd0, 5'd3, 5'd3, 5'd0, 3'd1, 32'd4)}) begin
      miscompares++;
      $display("FAIL start_keeps_word got v=%b instr=%h expected v=1 instr=%h",
               bus.out_valid, bus.out_instr, held);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({bus.out_valid, bus.out_instr, bus.out_addr, bus.out_err, bus.out_count} !==
        {1'b0, 32'h0, BASE, 1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL async_reset got v=%b i=%h a=%h e=%b c=%0d expected v=0 i=0 a=%h e=0 c=0",
               bus.out_valid, bus.out_instr, bus.out_addr, bus.out_err, bus.out_count, BASE);
    end
    sb.delete();
    model_addr = BASE;
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(2'd2, 5'd4, 5'd4, 5'd0, 3'd0, 32'd9);
    vectors++;
    if (bus.out_addr !== BASE) begin
      miscompares++;
      $display("FAIL post_reset_addr got %h expected %h", bus.out_addr, BASE);
    end
    idle_cycle();
  endtask

  initial begin
    test_reset();
    test_i_basic();
    test_load_store();
    test_branch();
    test_roundtrip();
    test_back_to_back();
    test_range();
    test_start();
    test_reset_mid();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20 && sb.size() != 0; c++) idle_cycle();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d words outstanding expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
